// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline SRAM paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam int MEM_BASE_DEF = 1024;
    localparam int SRAM_AW_DEF  = 18;
    localparam int WORD_W       = 32;
    localparam int HALF_W       = 16;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM halfword phase; raises last on the final hold cycle.
// Latency: last asserts WAIT_CYCLES-1 ticks after load.
// Backpressure: none; saturates at the last count instead of wrapping.
// Ports: clk/rst, load (clear to zero), tick (advance), last (final cycle of the phase).
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic last
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (tick && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_stage.sv
// ARM MEM stage: moves 32-bit words to/from a 16-bit async SRAM as two halfword phases.
// Latency: request in IDLE at cycle 0, DONE (ready=1, data valid) at cycle 2*WAIT_CYCLES+1.
// Backpressure: ready drops combinationally with a new request and freezes the pipeline until DONE.
// Ports: MEM_R_EN_MEM/MEM_W_EN_MEM/alu_res_MEM/val_Rm_MEM from EXE/MEM; data/ready to MEM/WB and
//        hazard logic; SRAM_* drive the external halfword SRAM (DQ split into in/out/oe).
module mem_sram_stage
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int MEM_BASE    = MEM_BASE_DEF,
    parameter int SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN_MEM,
    input  logic               MEM_W_EN_MEM,
    input  logic [31:0]        alu_res_MEM,
    input  logic [31:0]        val_Rm_MEM,
    output logic [31:0]        data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_OUT,
    input  logic [15:0]        SRAM_DQ_IN,
    output logic               SRAM_DQ_OE,
    output logic               SRAM_WE_N
);

    // With a single-cycle phase there is no cycle left to raise WE_N early.
    localparam bit SINGLE = (WAIT_CYCLES == 1);

    mem_state_t state, next_state;

    logic                 req;
    logic [31:0]          word_off;
    logic [SRAM_AW-2:0]   idx_q;
    logic [WORD_W-1:0]    wdat_q;
    logic                 op_wr_q;
    logic                 cnt_load;
    logic                 cnt_last;
    logic                 unused_bits;

    assign req      = MEM_R_EN_MEM | MEM_W_EN_MEM;
    assign word_off = (alu_res_MEM - 32'(MEM_BASE)) >> 2;
    assign unused_bits = ^word_off[31:SRAM_AW-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req)      next_state = LOW;
            LOW:     if (cnt_last) next_state = HIGH;
            HIGH:    if (cnt_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter restarts on every phase entry; it idles cleared outside the phases.
    assign cnt_load = (state != next_state) || (state == IDLE) || (state == DONE);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .tick (1'b1),
        .last (cnt_last)
    );

    // Output decode from state and latched request
    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = {idx_q, 1'b0};
        SRAM_DQ_OUT = wdat_q[HALF_W-1:0];
        SRAM_DQ_OE  = 1'b0;
        SRAM_WE_N   = 1'b1;
        case (state)
            IDLE: ready = ~req;
            LOW: begin
                SRAM_DQ_OE = op_wr_q;
                // WE_N rises on the last hold cycle so address/data outlast the write pulse.
                SRAM_WE_N  = ~(op_wr_q & (~cnt_last | SINGLE));
            end
            HIGH: begin
                SRAM_ADDR   = {idx_q, 1'b1};
                SRAM_DQ_OUT = wdat_q[WORD_W-1:HALF_W];
                SRAM_DQ_OE  = op_wr_q;
                SRAM_WE_N   = ~(op_wr_q & (~cnt_last | SINGLE));
            end
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Request latch: only sampled in IDLE; write wins when both enables are set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            wdat_q  <= '0;
            op_wr_q <= 1'b0;
        end else if (state == IDLE && req) begin
            idx_q   <= word_off[SRAM_AW-2:0];
            wdat_q  <= val_Rm_MEM;
            op_wr_q <= MEM_W_EN_MEM;
        end
    end

    // Load result, captured halfword by halfword on the last cycle of each read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (!op_wr_q && cnt_last) begin
            if (state == LOW) begin
                data[HALF_W-1:0] <= SRAM_DQ_IN;
            end else if (state == HIGH) begin
                data[WORD_W-1:HALF_W] <= SRAM_DQ_IN;
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Directed bench for mem_sram_stage with a behavioural 16-bit SRAM and a load scoreboard.
module tb_mem_sram_stage;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN_MEM;
    logic        MEM_W_EN_MEM;
    logic [31:0] alu_res_MEM;
    logic [31:0] val_Rm_MEM;
    logic [31:0] data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_DQ_OE;
    logic        SRAM_WE_N;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] sram  [0:63];
    logic [15:0] model [0:63];
    logic [31:0] exp_q [$];

    mem_sram_stage #(
        .WAIT_CYCLES(3),
        .MEM_BASE   (1024),
        .SRAM_AW    (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN_MEM(MEM_R_EN_MEM),
        .MEM_W_EN_MEM(MEM_W_EN_MEM),
        .alu_res_MEM (alu_res_MEM),
        .val_Rm_MEM  (val_Rm_MEM),
        .data        (data),
        .ready       (ready),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_WE_N   (SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: writes while WE_N is low and DQ driven, reads combinationally.
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR[5:0]] <= SRAM_DQ_OUT;
    end
    assign SRAM_DQ_IN = sram[SRAM_ADDR[5:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request just after a posedge and waits (bounded) for ready.
    // lat = cycle index of the first ready=1, we_tr = WE_N in cycles 1..6 (MSB first).
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [5:0] we_tr, output int done_cyc);
        int idx;
        idx = int'((addr - 32'd1024) >> 2);
        if (wr) begin
            model[2*idx]   = wd[15:0];
            model[2*idx+1] = wd[31:16];
        end else if (rd) begin
            exp_q.push_back({model[2*idx+1], model[2*idx]});
        end
        MEM_R_EN_MEM = rd;
        MEM_W_EN_MEM = wr;
        alu_res_MEM  = addr;
        val_Rm_MEM   = wd;
        lat      = -1;
        done_cyc = -1;
        we_tr    = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 6) we_tr[6-k] = SRAM_WE_N;
            if (ready) begin
                lat      = k;
                done_cyc = cyc;
                break;
            end
        end
        if (lat < 0) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else if (rd && !wr && exp_q.size() > 0) begin
            chk("load_data", data, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        MEM_R_EN_MEM = 1'b0;
        MEM_W_EN_MEM = 1'b0;
    endtask

    initial begin
        int          lat;
        int          d1;
        int          d2;
        logic [5:0]  we_tr;

        for (int i = 0; i < 64; i++) begin
            sram[i]  = 16'h0;
            model[i] = 16'h0;
        end
        rst          = 1'b1;
        MEM_R_EN_MEM = 1'b0;
        MEM_W_EN_MEM = 1'b0;
        alu_res_MEM  = 32'h0;
        val_Rm_MEM   = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset / idle state
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        chk("rst_dq_out", {16'd0, SRAM_DQ_OUT}, 32'd0);

        // Store 0x12345678 to 1024
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 32'd1024, 32'h12345678, lat, we_tr, d1);
        chk("st1_latency", lat, 32'd7);
        chk("st1_we_trace", {26'd0, we_tr}, 32'b001001);
        chk("st1_sram0", {16'd0, sram[0]}, 32'h5678);
        chk("st1_sram1", {16'd0, sram[1]}, 32'h1234);

        // Load it back, then data holds through idle cycles
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_tr, d1);
        chk("ld1_latency", lat, 32'd7);
        chk("ld1_we_trace", {26'd0, we_tr}, 32'b111111);
        repeat (3) @(negedge clk);
        chk("ld1_hold_data", data, 32'h12345678);
        chk("ld1_hold_ready", {31'd0, ready}, 32'd1);

        // Back-to-back store and load at 1028
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lat, we_tr, d1);
        access(1'b1, 1'b0, 32'd1028, 32'h0, lat, we_tr, d2);
        chk("b2b_done_gap", d2 - d1, 32'd8);
        chk("b2b_sram2", {16'd0, sram[2]}, 32'hBEEF);
        chk("b2b_sram3", {16'd0, sram[3]}, 32'hDEAD);

        // Both enables: treated as a write, data untouched
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lat, we_tr, d1);
        chk("both_latency", lat, 32'd7);
        chk("both_sram4", {16'd0, sram[4]}, 32'hF00D);
        chk("both_sram5", {16'd0, sram[5]}, 32'hCAFE);
        chk("both_data", data, 32'hDEADBEEF);

        // Reset during HIGH phase of a load
        MEM_R_EN_MEM = 1'b1;
        alu_res_MEM  = 32'd1024;
        repeat (5) @(posedge clk);
        #1;
        rst          = 1'b1;
        MEM_R_EN_MEM = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("mid_rst_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
        chk("mid_rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_tr, d1);
        chk("post_rst_latency", lat, 32'd7);
        chk("post_rst_data", data, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_sram_stage.md
# mem_sram_stage

Memory stage of the 32-bit ARM pipeline: takes the EXE/MEM register outputs and performs loads and stores against an external 16-bit asynchronous SRAM. Each 32-bit word is moved as two halfword transactions. A `ready` signal freezes the whole pipeline while a transaction is in flight. The block produces the 32-bit `data` that the MEM/WB register captures alongside `alu_res_MEM`.

## Interface
Parameters:
- WAIT_CYCLES, 3: cycles each halfword SRAM access is held (≥1).
- MEM_BASE, 1024: byte address mapped to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- MEM_R_EN_MEM  input  1  load request.
- MEM_W_EN_MEM  input  1  store request.
- alu_res_MEM  input  32  byte address (word-aligned).
- val_Rm_MEM  input  32  store data.
- data  output  32  load result, to MEM/WB register.
- ready  output  1  high = pipeline may advance; low = freeze all stage registers and PC.
- SRAM_ADDR  output  SRAM_AW  halfword address.
- SRAM_DQ_OUT  output  16  write data.
- SRAM_DQ_IN  input  16  read data.
- SRAM_DQ_OE  output  1  drive DQ (write phases only).
- SRAM_WE_N  output  1  active-low write enable.

## Operation
- Word index = (alu_res_MEM − MEM_BASE) >> 2, truncated to SRAM_AW−1 bits. Low halfword at {idx,0}, high halfword at {idx,1}. Bits [1:0] are ignored.
- FSM states:
  - IDLE: on (R_EN|W_EN), latch address, store data and op, then go to LOW.
  - LOW: hold WAIT_CYCLES cycles on the low halfword, then go to HIGH.
  - HIGH: same on the high halfword, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Write precedence: if R_EN and W_EN are both asserted, the access is a write and `data` is unchanged.
- Write phases:
  - SRAM_DQ_OE=1, SRAM_WE_N=0 for the first WAIT_CYCLES−1 cycles of the phase and 1 on its last cycle (address and data stable while WE_N rises).
  - With WAIT_CYCLES=1, WE_N=0 for the single cycle.
- Read phases: DQ_OE=0, WE_N=1. SRAM_DQ_IN is sampled on the last cycle of LOW into data[15:0] and on the last cycle of HIGH into data[31:16].
- `ready` = (IDLE & ~(R_EN|W_EN)) | DONE. This is combinational, so a new request freezes the pipeline in the same cycle it appears.
- `data` is registered and holds its value between loads.
- SRAM outputs are decoded from the state and latched registers. In IDLE/DONE: ADDR=latched low address, OE=0, WE_N=1.

## Timing
- Request seen in IDLE at cycle 0 → LOW cycles 1..W → HIGH cycles W+1..2W → DONE at cycle 2W+1 with ready=1 and `data` valid. With W=3: ready=1 at cycle 7.
- Request inputs stay stable while ready=0 (the pipeline is frozen); the block does not re-sample them outside IDLE.
- Back-to-back accesses: the following instruction's request arrives in the cycle after DONE (IDLE). ready is low again in that same cycle, so there is no bubble beyond one IDLE cycle.
- Reset values: state=IDLE, data=0, latched address/data/op=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, SRAM_WE_N=1. ready follows the IDLE rule.
- Reset mid-transaction aborts immediately. The partial write may leave one halfword updated; this is accepted.
- Wait counter: width ⌈log2(WAIT_CYCLES+1)⌉, cleared on every phase entry, no wrap.

## Structure
- Shared package `arm_pkg`: `mem_state_t` enum {IDLE, LOW, HIGH, DONE}, MEM_BASE and SRAM_AW defaults, and the word/halfword width constants.
- One sub-module is natural: `sram_wait_counter` (load, tick, `last` flag), reused later by the instruction-fetch SRAM path. The FSM and datapath live in this module.

## Test plan
- Idle, no requests → ready=1, SRAM_WE_N=1, SRAM_DQ_OE=0, data=0 after reset.
- Store 0x12345678 to 1024, W=3 → SRAM[0]=0x5678, SRAM[1]=0x1234; ready low cycles 0–6, high at cycle 7; WE_N low 2 cycles per phase.
- Load from 1024 after that store → data=0x12345678 in the DONE cycle; data holds through following non-memory instructions.
- Store 0xDEADBEEF to 1028, then load 1028 back-to-back → SRAM[2]=0xBEEF, SRAM[3]=0xDEAD; load returns 0xDEADBEEF; exactly one IDLE cycle between the two DONEs.
- R_EN and W_EN both high with addr 1032 → write performed to SRAM[4]/[5], data unchanged.
- rst asserted during HIGH of a load → next cycle state=IDLE, data=0, WE_N=1, OE=0; a subsequent load completes normally.
